dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Sequenced two-requester arbiter for the core's single-port data memory. It shares the memory between the pipeline MEM stage (core port) and an external loader/debug port (ext port). Each access is a fixed three-phase transaction: accept, issue, respond. The block sits between the Datapath MEM stage and the data memory, and drives the memory-side wr/rd/addr/wr_data signals the top level exports.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 9, word address width into data memory
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- core_req / ext_req  in  1  request valid, one per port
- core_we / ext_we  in  1  1 = write, 0 = read
- core_addr / ext_addr  in  ADDR_W  access address
- core_wdata / ext_wdata  in  DATA_W  write data
- core_ack / ext_ack  out  1  request accepted this cycle (combinational, IDLE only)
- core_done / ext_done  out  1  one-cycle pulse, transaction complete
- core_rdata / ext_rdata  out  DATA_W  read data, valid with done on reads
- mem_rd / mem_wr  out  1  memory strobes
- mem_addr  out  ADDR_W  registered address
- mem_wr_data  out  DATA_W  registered write data
- mem_rd_data  in  DATA_W  memory read data, one cycle after mem_rd

## Operation
- FSM states are IDLE, ISSUE and RESP.
- IDLE:
  - If any req is high, pick a winner and assert only its ack.
  - At the clock edge, latch the winner's id, we, addr and wdata, then go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE:
  - Drive mem_addr and mem_wr_data from the latched registers.
  - Assert mem_wr if the latched we is 1, else assert mem_rd.
  - Go to RESP.
- RESP:
  - Pulse done for the latched id.
  - On a read, present mem_rd_data on that id's rdata. On a write, rdata holds its last value.
  - Go to IDLE.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack is seen.
  - At most one transaction is outstanding across both ports.
  - A requester may reassert req in the same cycle as its done; it is accepted no earlier than the following IDLE cycle.
- Winner selection with the round-robin macro absent: core has fixed priority over ext.
- ack is never asserted outside IDLE. A req arriving in ISSUE or RESP waits.
- A req that drops before ack is simply not served; there is no error.
- The address is not range-checked. It wraps within ADDR_W bits.

## Timing
- Reset values: FSM = IDLE; mem_rd, mem_wr, both acks and both dones = 0; mem_addr, mem_wr_data and both rdata = 0; latched id = core; round-robin pointer = core.
- Latency: ack in cycle N → mem strobe in N+1 → done (and rdata) in N+2.
- Throughput: one transaction per 3 cycles.
- Write data lands in memory at the end of N+1.
- Reset asserted mid-transaction: go to IDLE immediately (asynchronous). The pending transaction is dropped, and no done is ever issued for it.
- Reset deasserted: the first ack is possible in the first IDLE cycle after release.
- Both req high in IDLE: exactly one ack is asserted; the loser's req stays pending.

## Configuration
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- When defined:
  - A 1-bit last-grant pointer is kept, updated on each ack.
  - On simultaneous requests, the port not granted last wins.
  - A single requester always wins regardless of the pointer.
- When undefined: there is no pointer register, and core always beats ext.

## Structure
- dmem_arb_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, RESP};
  - arb_id_t enum {ID_CORE, ID_EXT};
  - localparam defaults for DATA_W and ADDR_W.
- One sub-module, dmem_arb_pick, is combinational winner selection. Its inputs are both reqs and the pointer; its outputs are the grant id and grant valid. The round-robin logic is `ifdef`-guarded inside it.

## Test plan
- Core read alone: preload mem[0x010]=0xDEADBEEF, core_req read 0x010 → core_ack cycle N, mem_rd cycle N+1 with mem_addr=0x010, core_done and core_rdata=0xDEADBEEF in N+2.
- Ext write then core read: ext writes 0x0A5=0x12345678, then core reads 0x0A5 → ext_done in N+2, and core_rdata=0x12345678 three cycles later.
- Simultaneous requests with macro absent, both req held for 4 transactions → grant order core, core, core, core; ext is never acked while core_req stays high.
- Simultaneous requests with DMEM_ARB_ROUND_ROBIN_EN defined, both held → grant order core, ext, core, ext; acks are 3 cycles apart.
- Reset in ISSUE during an ext write to 0x1FF → FSM returns to IDLE, no ext_done occurs, and all outputs read 0 while reset is high.
- Address wrap: ext read at 0x1FF, then core read at 0x000 → mem_addr shows 0x1FF then 0x000, and each done occurs exactly once.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and width defaults for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 9;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;

    typedef enum logic {ID_CORE, ID_EXT} arb_id_t;

    function automatic arb_id_t other_id(arb_id_t id);
        return id == ID_CORE ? ID_EXT : ID_CORE;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner selection between the core and ext ports.
// With DMEM_ARB_ROUND_ROBIN_EN defined, ties go to the port named by ptr_i;
// otherwise core always beats ext.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic core_req_i,
    input  logic ext_req_i,
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    input  logic ptr_i,
`endif
    output logic gnt_id_o,
    output logic gnt_vld_o
);

    arb_id_t gnt;

    // A lone requester always wins; only a tie consults the pointer.
    always_comb begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        gnt = (core_req_i && ext_req_i) ? arb_id_t'(ptr_i) : (core_req_i ? ID_CORE : ID_EXT);
`else
        gnt = core_req_i ? ID_CORE : ID_EXT;
`endif
        gnt_id_o  = gnt;
        gnt_vld_o = core_req_i || ext_req_i;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage (core)
// and the loader/debug port (ext) with a fixed accept/issue/respond sequence.
// Optional round-robin tie-break is enabled by defining DMEM_ARB_ROUND_ROBIN_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic              core_ack_o,
    output logic              core_done_o,
    output logic [DATA_W-1:0] core_rdata_o,
    input  logic              ext_req_i,
    input  logic              ext_we_i,
    input  logic [ADDR_W-1:0] ext_addr_i,
    input  logic [DATA_W-1:0] ext_wdata_i,
    output logic              ext_ack_o,
    output logic              ext_done_o,
    output logic [DATA_W-1:0] ext_rdata_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wr_data_o,
    input  logic [DATA_W-1:0] mem_rd_data_i
);

    arb_state_t        state_q;
    arb_id_t           id_q;
    logic              we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wr_data_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic              core_done_q;
    logic              ext_done_q;
    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] ext_rdata_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Names the port that wins the next tie; flips away from every winner.
    arb_id_t           ptr_q;
`endif

    logic              gnt_raw;
    logic              gnt_vld;
    arb_id_t           gnt_id;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rd_resp;

    dmem_arb_pick u_pick (
        .core_req_i (core_req_i),
        .ext_req_i  (ext_req_i),
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        .ptr_i      (ptr_q),
`endif
        .gnt_id_o   (gnt_raw),
        .gnt_vld_o  (gnt_vld)
    );

    // Steer the winner's request fields toward the latch registers and decode response phase.
    always_comb begin
        gnt_id    = arb_id_t'(gnt_raw);
        accept    = state_q == IDLE && gnt_vld && !reset_i;
        sel_we    = gnt_id == ID_EXT ? ext_we_i : core_we_i;
        sel_addr  = gnt_id == ID_EXT ? ext_addr_i : core_addr_i;
        sel_wdata = gnt_id == ID_EXT ? ext_wdata_i : core_wdata_i;
        rd_resp   = state_q == RESP && !we_q;
    end

    assign core_ack_o    = accept && gnt_id == ID_CORE;
    assign ext_ack_o     = accept && gnt_id == ID_EXT;
    assign mem_rd_o      = mem_rd_q;
    assign mem_wr_o      = mem_wr_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wr_data_o = mem_wr_data_q;
    assign core_done_o   = core_done_q;
    assign ext_done_o    = ext_done_q;
    // Read data arrives from memory during RESP, so it is forwarded alongside done and captured for later.
    assign core_rdata_o  = (rd_resp && id_q == ID_CORE) ? mem_rd_data_i : core_rdata_q;
    assign ext_rdata_o   = (rd_resp && id_q == ID_EXT) ? mem_rd_data_i : ext_rdata_q;

    // Transaction sequencer: latch the winner in IDLE, strobe memory in ISSUE, pulse done in RESP.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            id_q          <= ID_CORE;
            we_q          <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            core_done_q   <= 1'b0;
            ext_done_q    <= 1'b0;
            core_rdata_q  <= '0;
            ext_rdata_q   <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            ptr_q         <= ID_CORE;
`endif
        end else begin
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            core_done_q <= 1'b0;
            ext_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        id_q          <= gnt_id;
                        we_q          <= sel_we;
                        mem_addr_q    <= sel_addr;
                        mem_wr_data_q <= sel_wdata;
                        mem_wr_q      <= sel_we;
                        mem_rd_q      <= !sel_we;
                        state_q       <= ISSUE;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                        ptr_q         <= other_id(gnt_id);
`endif
                    end
                end
                ISSUE: begin
                    core_done_q <= id_q == ID_CORE;
                    ext_done_q  <= id_q == ID_EXT;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (!we_q && id_q == ID_CORE) core_rdata_q <= mem_rd_data_i;
                    if (!we_q && id_q == ID_EXT) ext_rdata_q <= mem_rd_data_i;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus against a transaction-level reference model of the arbiter.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_req = 1'b0, core_we = 1'b0, ext_req = 1'b0, ext_we = 1'b0;
    logic [8:0]  core_addr = '0, ext_addr = '0;
    logic [31:0] core_wdata = '0, ext_wdata = '0;
    logic        core_ack, core_done, ext_ack, ext_done, mem_rd, mem_wr;
    logic [31:0] core_rdata, ext_rdata, mem_wr_data;
    logic [31:0] mem_rd_data = '0;
    logic [8:0]  mem_addr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int dn_c = 0, dn_e = 0;

    logic [31:0] mem [512];
    logic [31:0] ref_mem [512];

    dmem_arbiter dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .core_req_i    (core_req),
        .core_we_i     (core_we),
        .core_addr_i   (core_addr),
        .core_wdata_i  (core_wdata),
        .core_ack_o    (core_ack),
        .core_done_o   (core_done),
        .core_rdata_o  (core_rdata),
        .ext_req_i     (ext_req),
        .ext_we_i      (ext_we),
        .ext_addr_i    (ext_addr),
        .ext_wdata_i   (ext_wdata),
        .ext_ack_o     (ext_ack),
        .ext_done_o    (ext_done),
        .ext_rdata_o   (ext_rdata),
        .mem_rd_o      (mem_rd),
        .mem_wr_o      (mem_wr),
        .mem_addr_o    (mem_addr),
        .mem_wr_data_o (mem_wr_data),
        .mem_rd_data_i (mem_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port memory: write at the edge, read data one cycle after mem_rd.
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wr_data;
        if (mem_rd) mem_rd_data <= mem[mem_addr];
    end

    always @(negedge clk) begin
        dn_c <= dn_c + int'(core_done);
        dn_e <= dn_e + int'(ext_done);
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, cyc);
        end
    endtask

    // Reference model: each accepted transaction is a record with its accept cycle;
    // strobe is due at +1, done at +2, and the next accept no earlier than +3.
    int          acc = -10, next_free = 0;
    bit          t_id = 1'b0, t_we = 1'b0, pref = 1'b0;
    logic [8:0]  t_addr = '0, e_addr = '0;
    logic [31:0] t_wd = '0, e_wd = '0, e_rdc = '0, e_rde = '0;

    always @(negedge clk) begin
        bit ec, ee, erd, ewr, edc, ede, w;
        ec = 0; ee = 0; erd = 0; ewr = 0; edc = 0; ede = 0; w = 0;
        if (reset) begin
            acc = -10; next_free = cyc; e_addr = '0; e_wd = '0; e_rdc = '0; e_rde = '0; pref = 1'b0;
        end else begin
            erd = (cyc == acc + 1) && !t_we;
            ewr = (cyc == acc + 1) && t_we;
            edc = (cyc == acc + 2) && !t_id;
            ede = (cyc == acc + 2) && t_id;
            if (cyc == acc + 2 && !t_we) begin
                if (t_id) e_rde = ref_mem[t_addr];
                else e_rdc = ref_mem[t_addr];
            end
            if (cyc >= next_free && (core_req || ext_req)) begin
                w = (core_req && ext_req) ? (RR ? pref : 1'b0) : ext_req;
                ec = !w;
                ee = w;
            end
        end
        chk("core_ack", core_ack, ec);
        chk("ext_ack", ext_ack, ee);
        chk("mem_rd", mem_rd, erd);
        chk("mem_wr", mem_wr, ewr);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wr_data", mem_wr_data, e_wd);
        chk("core_done", core_done, edc);
        chk("ext_done", ext_done, ede);
        chk("core_rdata", core_rdata, e_rdc);
        chk("ext_rdata", ext_rdata, e_rde);
        if (!reset) begin
            if (cyc == acc + 1 && t_we) ref_mem[t_addr] = t_wd;
            if (ec || ee) begin
                t_id = ee;
                t_we = ee ? ext_we : core_we;
                t_addr = ee ? ext_addr : core_addr;
                t_wd = ee ? ext_wdata : core_wdata;
                acc = cyc;
                next_free = cyc + 3;
                e_addr = t_addr;
                e_wd = t_wd;
                pref = !ee;
            end
        end
    end

    task automatic xfer(input bit ext, input bit we, input logic [8:0] a, input logic [31:0] d, output int ac);
        bit seen;
        seen = 1'b0;
        ac = -1;
        if (ext) begin
            ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
        end else begin
            core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d;
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = ext ? ext_ack : core_ack;
            if (seen) ac = cyc;
        end
        chk("ack_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        if (ext) ext_req = 1'b0;
        else core_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, ea, ca, n, sc, se;
        bit g [4];
        int gc [4];
        bit exp_g [4];
        exp_g = RR ? '{1'b0, 1'b1, 1'b0, 1'b1} : '{1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 512; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        mem[9'h010] = 32'hDEADBEEF; ref_mem[9'h010] = 32'hDEADBEEF;
        mem[9'h1FF] = 32'hCAFEF00D; ref_mem[9'h1FF] = 32'hCAFEF00D;
        mem[9'h000] = 32'h0BADF00D; ref_mem[9'h000] = 32'h0BADF00D;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Core read alone.
        xfer(1'b0, 1'b0, 9'h010, 32'h0, na);
        @(negedge clk);
        chk("t1_mem_rd", mem_rd, 1);
        chk("t1_mem_addr", mem_addr, 32'h010);
        @(negedge clk);
        chk("t1_core_done", core_done, 1);
        chk("t1_core_rdata", core_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Ext write then core read of the same word.
        xfer(1'b1, 1'b1, 9'h0A5, 32'h12345678, ea);
        @(negedge clk);
        chk("t2_mem_wr", mem_wr, 1);
        @(negedge clk);
        chk("t2_ext_done", ext_done, 1);
        @(posedge clk); #1;
        xfer(1'b0, 1'b0, 9'h0A5, 32'h0, ca);
        chk("t2_ack_spacing", ca, ea + 3);
        repeat (2) @(negedge clk);
        chk("t2_core_done", core_done, 1);
        chk("t2_core_rdata", core_rdata, 32'h12345678);
        @(posedge clk); #1;

        // Both ports held high from a fresh reset.
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 9'h010;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 9'h0A5;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (core_ack || ext_ack) begin
                g[n] = ext_ack;
                gc[n] = cyc;
                n++;
            end
        end
        chk("t3_grant_count", n, 4);
        for (int i = 0; i < n; i++) begin
            chk("t3_grant_id", {31'd0, g[i]}, {31'd0, exp_g[i]});
            if (i > 0) chk("t3_grant_gap", gc[i] - gc[i-1], 3);
        end
        @(posedge clk); #1;
        core_req = 1'b0; ext_req = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Reset while an ext write to 0x1FF is in ISSUE: dropped, never completes.
        se = dn_e;
        xfer(1'b1, 1'b1, 9'h1FF, 32'h55AA55AA, ea);
        reset = 1'b1;
        @(negedge clk);
        chk("t4_rst_mem_wr", mem_wr, 0);
        chk("t4_rst_mem_addr", mem_addr, 0);
        chk("t4_rst_ext_rdata", ext_rdata, 0);
        repeat (2) @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("t4_no_ext_done", dn_e - se, 0);

        // Address extremes: ext read 0x1FF then core read 0x000.
        sc = dn_c;
        se = dn_e;
        xfer(1'b1, 1'b0, 9'h1FF, 32'h0, ea);
        @(negedge clk);
        chk("t5_mem_addr_hi", mem_addr, 32'h1FF);
        @(negedge clk);
        chk("t5_ext_rdata", ext_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;
        xfer(1'b0, 1'b0, 9'h000, 32'h0, ca);
        @(negedge clk);
        chk("t5_mem_addr_lo", mem_addr, 32'h000);
        @(negedge clk);
        chk("t5_core_rdata", core_rdata, 32'h0BADF00D);
        repeat (4) @(posedge clk); #1;
        chk("t5_core_done_once", dn_c - sc, 1);
        chk("t5_ext_done_once", dn_e - se, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
